// File: rtl/wave_instr_feeder_pkg.sv
// Shared constants and FSM encoding for the wavepool -> decode instruction feeder.
package wave_instr_feeder_pkg;

  localparam int NUM_WF_DEF = 40;
  localparam int WFID_W     = 6;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    GAP  = 2'd1,
    HALF = 2'd2
  } fsm_e;

  // Round-robin successor of a wavefront index, wrapping at n.
  function automatic logic [WFID_W-1:0] rr_next(input logic [WFID_W-1:0] idx, input int n);
    if (int'(idx) + 1 >= n) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/wave_instr_feeder_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i wins, wrapping at N.
module wave_instr_feeder_rr_arbiter
  import wave_instr_feeder_pkg::*;
#(
  parameter int N = NUM_WF_DEF
) (
  input  logic [N-1:0]      req_i,
  input  logic [WFID_W-1:0] ptr_i,
  output logic [N-1:0]      gnt_o,
  output logic [WFID_W-1:0] idx_o,
  output logic              vld_o
);

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        idx_o    = WFID_W'(j);
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wave_instr_feeder.sv
// Per-wavefront dword buffers, round-robin first-dword issue and priority second-half issue to decode.
module wave_instr_feeder
  import wave_instr_feeder_pkg::*;
#(
  parameter int NUM_WF = NUM_WF_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_wr_valid,
  input  logic [WFID_W-1:0] fetch_wr_wfid,
  input  logic [31:0]       fetch_wr_instr,
  input  logic [31:0]       fetch_wr_pc,
  input  logic              wf_init_valid,
  input  logic [WFID_W-1:0] wf_init_wfid,
  input  logic [9:0]        wf_init_vgpr_base,
  input  logic [8:0]        wf_init_sgpr_base,
  input  logic [15:0]       wf_init_lds_base,
  input  logic              wf_flush_valid,
  input  logic [WFID_W-1:0] wf_flush_wfid,
  input  logic [NUM_WF-1:0] issue_ready,
  input  logic              wave_ins_half_rqd,
  input  logic [WFID_W-1:0] wave_ins_half_wfid,
  output logic              wave_instr_valid,
  output logic [31:0]       wave_instr,
  output logic [31:0]       wave_instr_pc,
  output logic [WFID_W-1:0] wave_wfid,
  output logic [9:0]        wave_vgpr_base,
  output logic [8:0]        wave_sgpr_base,
  output logic [15:0]       wave_lds_base,
  output logic [NUM_WF-1:0] buff_full,
  output logic              proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      instr_mem_q [NUM_WF][DEPTH];
  logic [31:0]      pc_mem_q    [NUM_WF][DEPTH];
  logic [PTR_W-1:0] rd_q [NUM_WF];
  logic [PTR_W-1:0] wr_q [NUM_WF];
  logic [CNT_W-1:0] cnt_q [NUM_WF];
  logic [9:0]       vgpr_tbl_q [NUM_WF];
  logic [8:0]       sgpr_tbl_q [NUM_WF];
  logic [15:0]      lds_tbl_q  [NUM_WF];

  fsm_e              state_q, state_d;
  logic [WFID_W-1:0] lock_q, lock_d, rr_q, rr_d;
  logic              second_q, second_d;

  logic [NUM_WF-1:0] req, gnt, wr_vec, fl_vec, wr_acc, pop_vec;
  logic [WFID_W-1:0] gnt_idx, pop_wf;
  logic              gnt_vld, pop_en, mis, ovf;

  always_comb begin
    req       = '0;
    wr_vec    = '0;
    fl_vec    = '0;
    wr_acc    = '0;
    buff_full = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      buff_full[i] = (cnt_q[i] == CNT_W'(DEPTH));
      req[i]       = (cnt_q[i] != '0) && issue_ready[i];
      wr_vec[i]    = fetch_wr_valid && (fetch_wr_wfid == WFID_W'(i));
      fl_vec[i]    = wf_flush_valid && (wf_flush_wfid == WFID_W'(i));
      // A full buffer still accepts a write when its head leaves in the same cycle.
      wr_acc[i]    = wr_vec[i] && !fl_vec[i] && (!buff_full[i] || pop_vec[i]);
    end
    ovf = |(wr_vec & ~fl_vec & buff_full & ~pop_vec);
  end

  wave_instr_feeder_rr_arbiter #(.N(NUM_WF)) u_rr (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    rr_d     = rr_q;
    second_d = second_q;
    pop_en   = 1'b0;
    pop_wf   = lock_q;
    pop_vec  = '0;
    mis      = 1'b0;
    unique case (state_q)
      ARB: if (gnt_vld) begin
        pop_en   = 1'b1;
        pop_wf   = gnt_idx;
        pop_vec  = gnt;
        lock_d   = gnt_idx;
        rr_d     = rr_next(gnt_idx, NUM_WF);
        second_d = 1'b0;
        state_d  = GAP;
      end
      GAP: begin
        state_d = ARB;
        // Only one extra dword per instruction: a request after a second half is an error.
        if (wave_ins_half_rqd) begin
          if (wave_ins_half_wfid == lock_q && !second_q) state_d = HALF;
          else                                           mis     = 1'b1;
        end
      end
      HALF: if (cnt_q[lock_q] != '0) begin
        pop_en          = 1'b1;
        pop_vec[lock_q] = 1'b1;
        second_d        = 1'b1;
        state_d         = GAP;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ARB;
      lock_q   <= '0;
      rr_q     <= '0;
      second_q <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      rr_q     <= rr_d;
      second_q <= second_d;
      if (ovf || mis) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WF; i++) begin
        cnt_q[i] <= '0;
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WF; i++) begin
        if (fl_vec[i]) begin
          cnt_q[i] <= '0;
          rd_q[i]  <= '0;
          wr_q[i]  <= '0;
        end else begin
          if (pop_vec[i]) rd_q[i] <= rd_q[i] + PTR_W'(1);
          if (wr_acc[i])  wr_q[i] <= wr_q[i] + PTR_W'(1);
          if (wr_acc[i] && !pop_vec[i])      cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          else if (!wr_acc[i] && pop_vec[i]) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (|wr_acc) begin
      instr_mem_q[fetch_wr_wfid][wr_q[fetch_wr_wfid]] <= fetch_wr_instr;
      pc_mem_q[fetch_wr_wfid][wr_q[fetch_wr_wfid]]    <= fetch_wr_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WF; i++) begin
        vgpr_tbl_q[i] <= '0;
        sgpr_tbl_q[i] <= '0;
        lds_tbl_q[i]  <= '0;
      end
    end else if (wf_init_valid && int'(wf_init_wfid) < NUM_WF) begin
      vgpr_tbl_q[wf_init_wfid] <= wf_init_vgpr_base;
      sgpr_tbl_q[wf_init_wfid] <= wf_init_sgpr_base;
      lds_tbl_q[wf_init_wfid]  <= wf_init_lds_base;
    end
  end

  // Output register: bases come from the table before any same-edge init lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wave_instr_valid <= 1'b0;
      wave_instr       <= '0;
      wave_instr_pc    <= '0;
      wave_wfid        <= '0;
      wave_vgpr_base   <= '0;
      wave_sgpr_base   <= '0;
      wave_lds_base    <= '0;
    end else begin
      wave_instr_valid <= pop_en;
      if (pop_en) begin
        wave_instr     <= instr_mem_q[pop_wf][rd_q[pop_wf]];
        wave_instr_pc  <= pc_mem_q[pop_wf][rd_q[pop_wf]];
        wave_wfid      <= pop_wf;
        wave_vgpr_base <= vgpr_tbl_q[pop_wf];
        wave_sgpr_base <= sgpr_tbl_q[pop_wf];
        wave_lds_base  <= lds_tbl_q[pop_wf];
      end
    end
  end

endmodule
